// File: rtl/mem_arbiter_n.sv
// N-channel arbiter in front of the single memory controller: picks one requester
// (round-robin or fixed priority), runs one block transaction, pulses resp_done.
module mem_arbiter_n #(
  parameter int NCHAN   = 2,
  parameter int ADDR_W  = 64,
  parameter int BLOCK_W = 512,
  parameter int RR      = 1,
  localparam int GID_W  = (NCHAN > 1) ? $clog2(NCHAN) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NCHAN-1:0]         req_valid,
  input  logic [NCHAN-1:0]         req_wr,
  input  logic [NCHAN*ADDR_W-1:0]  req_addr,
  input  logic [NCHAN*BLOCK_W-1:0] req_wdata,
  output logic [NCHAN-1:0]         resp_done,
  output logic [BLOCK_W-1:0]       resp_data,
  output logic [GID_W-1:0]         grant_id,
  output logic                     busy,
  output logic                     mem_req,
  output logic                     mem_wr_en,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [BLOCK_W-1:0]       mem_wdata,
  input  logic [BLOCK_W-1:0]       mem_data_in,
  input  logic                     mem_data_valid
);

  typedef enum logic [1:0] {IDLE, MEM, RESP} state_t;

  state_t             state_q;
  logic [GID_W-1:0]   last_q;
  logic [GID_W-1:0]   grant_q;
  logic [NCHAN-1:0]   resp_done_q;
  logic [BLOCK_W-1:0] resp_data_q;
  logic               busy_q;
  logic               mem_req_q;
  logic               mem_wr_en_q;
  logic [ADDR_W-1:0]  mem_addr_q;
  logic [BLOCK_W-1:0] mem_wdata_q;

  logic [GID_W-1:0]   win_d;
  logic [GID_W-1:0]   low_d;
  logic [GID_W-1:0]   high_d;
  logic               found_high_d;
  logic [ADDR_W-1:0]  sel_addr_d;
  logic [BLOCK_W-1:0] sel_wdata_d;
  logic               sel_wr_d;

  // Round-robin = lowest requester above the last grant, else wrap to the lowest overall.
  always_comb begin
    low_d        = '0;
    high_d       = '0;
    found_high_d = 1'b0;
    for (int i = NCHAN - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        low_d = GID_W'(i);
        if (i > int'(last_q)) begin
          high_d       = GID_W'(i);
          found_high_d = 1'b1;
        end
      end
    end
    win_d = ((RR != 0) && found_high_d) ? high_d : low_d;

    sel_addr_d  = '0;
    sel_wdata_d = '0;
    sel_wr_d    = 1'b0;
    for (int i = 0; i < NCHAN; i++) begin
      if (int'(win_d) == i) begin
        sel_addr_d  = req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata_d = req_wdata[i*BLOCK_W +: BLOCK_W];
        sel_wr_d    = req_wr[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      last_q      <= GID_W'(NCHAN - 1);
      grant_q     <= '0;
      resp_done_q <= '0;
      resp_data_q <= '0;
      busy_q      <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_wr_en_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          resp_done_q <= '0;
          if (|req_valid) begin
            mem_addr_q  <= sel_addr_d;
            mem_wdata_q <= sel_wdata_d;
            mem_wr_en_q <= sel_wr_d;
            grant_q     <= win_d;
            last_q      <= win_d;
            mem_req_q   <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= MEM;
          end
        end
        MEM: begin
          if (mem_data_valid) begin
            if (!mem_wr_en_q) resp_data_q <= mem_data_in;
            resp_done_q <= NCHAN'(1) << grant_q;
            mem_req_q   <= 1'b0;
            state_q     <= RESP;
          end
        end
        RESP: begin
          resp_done_q <= '0;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
        default: begin
          resp_done_q <= '0;
          mem_req_q   <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign resp_done = resp_done_q;
  assign resp_data = resp_data_q;
  assign grant_id  = grant_q;
  assign busy      = busy_q;
  assign mem_req   = mem_req_q;
  assign mem_wr_en = mem_wr_en_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule
